// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multi-cycle RISC-V core (option macro: BRANCH_EXT_EN enables bne/blt/bge)
module multicycle_controller #(
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                lt,
    input  logic                gte,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_SUB  = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_AND  = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_OR   = ALUCTL_W'(3);
    localparam logic [ALUCTL_W-1:0] ALU_XOR  = ALUCTL_W'(4);
    localparam logic [ALUCTL_W-1:0] ALU_SLT  = ALUCTL_W'(5);
    localparam logic [ALUCTL_W-1:0] ALU_SLTU = ALUCTL_W'(6);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRWB,
        S_LUI,
        S_ILLEGAL
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t out_state;

    logic alu_f3_ok;
    logic branch_f3_ok;
    logic branch_taken;
    logic [ALUCTL_W-1:0] alu_func;

    // Shift funct3 encodings trap at decode.
    assign alu_f3_ok = (funct3 != 3'b001) && (funct3 != 3'b101);

`ifdef BRANCH_EXT_EN
    assign branch_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
`else
    assign branch_f3_ok = (funct3 == 3'b000);
`endif

    // Branch condition from the flags of the comparison running this cycle.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
`ifdef BRANCH_EXT_EN
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = gte;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

    // ALU function for register and immediate arithmetic; funct7b5 only selects sub for R-type.
    always_comb begin
        alu_func = ALU_ADD;
        case (funct3)
            3'b000:  alu_func = (funct7b5 && state_q == S_EXECR) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_func = ALU_AND;
            3'b110:  alu_func = ALU_OR;
            3'b100:  alu_func = ALU_XOR;
            3'b010:  alu_func = ALU_SLT;
            3'b011:  alu_func = ALU_SLTU;
            default: alu_func = ALU_ADD;
        endcase
    end

    // State register; reset returns to FETCH and aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing through the instruction phases.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = alu_f3_ok ? S_EXECR : S_ILLEGAL;
                    OP_ITYPE:  state_d = alu_f3_ok ? S_EXECI : S_ILLEGAL;
                    OP_BRANCH: state_d = branch_f3_ok ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    default:   state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRWB;
            S_JALRWB:   state_d = S_FETCH;
            S_LUI:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held the datapath sees FETCH settings, so decode outputs from FETCH.
    assign out_state = rst ? S_FETCH : state_q;

    // Output decode of the (effective) state, with every enable suppressed during reset.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (out_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ResultSrc = RES_MEM;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = alu_func;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUControl = alu_func;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = branch_taken;
            end
            S_JAL: begin
                PCWrite   = 1'b1;
                ResultSrc = RES_ALUOUT;
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_I;
                ResultSrc = RES_ALURES;
                PCWrite   = 1'b1;
            end
            S_JALRWB: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                RegWrite  = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule
